// File: rtl/char_queue_pkg.sv
// Shared types and constants for the debounced character input queue.
package char_queue_pkg;

  localparam int unsigned CHAR_W            = 7;
  localparam int unsigned DEPTH_DEFAULT     = 4;
  localparam int unsigned DEB_TICKS_DEFAULT = 3;
  localparam int unsigned TICK_W            = 4;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_ARM_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_ARM_LOW  = 2'd3
  } deb_state_e;

  // Raw pin bundle carried through the synchronizer as one bus
  typedef struct packed {
    logic              strobe;
    logic [CHAR_W-1:0] ch;
  } raw_in_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, async active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/char_input_queue.sv
// Debounces a bouncy character strobe and queues the characters for a consumer.
module char_input_queue
  import char_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned DEB_TICKS = DEB_TICKS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       strobe_in,
  input  logic [CHAR_W-1:0]          char_in,
  input  logic                       deb_tick,
  input  logic                       clear_ovf,
  output logic                       char_valid,
  output logic [CHAR_W-1:0]          char_data,
  input  logic                       char_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  raw_in_t raw;
  raw_in_t syn;

  assign raw = {strobe_in, char_in};

  sync_2ff #(.WIDTH($bits(raw_in_t))) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw),
    .q     (syn)
  );

  // Debounce FSM
  deb_state_e        state, state_nxt;
  logic [TICK_W-1:0] tick_cnt, tick_nxt, tick_inc;
  logic              last_tick_c;
  logic              press_c;

  assign tick_inc    = tick_cnt + TICK_W'(1);
  assign last_tick_c = (tick_inc == TICK_W'(DEB_TICKS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LOW;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    press_c   = 1'b0;
    case (state)
      ST_LOW: begin
        if (syn.strobe) begin
          state_nxt = ST_ARM_HIGH;
          tick_nxt  = '0;
        end
      end
      ST_ARM_HIGH: begin
        if (!syn.strobe) begin
          state_nxt = ST_LOW;
        end else if (deb_tick) begin
          if (last_tick_c) begin
            state_nxt = ST_HIGH;
            tick_nxt  = '0;
            press_c   = 1'b1;
          end else begin
            tick_nxt = tick_inc;
          end
        end
      end
      ST_HIGH: begin
        if (!syn.strobe) begin
          state_nxt = ST_ARM_LOW;
          tick_nxt  = '0;
        end
      end
      ST_ARM_LOW: begin
        if (syn.strobe) begin
          state_nxt = ST_HIGH;
        end else if (deb_tick) begin
          if (last_tick_c) begin
            state_nxt = ST_LOW;
            tick_nxt  = '0;
          end else begin
            tick_nxt = tick_inc;
          end
        end
      end
      default: begin
        state_nxt = ST_LOW;
        tick_nxt  = '0;
      end
    endcase
  end

  // FIFO
  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head, tail, head_nxt, tail_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [CHAR_W-1:0] data_nxt;
  logic              ovf_nxt;
  logic              pop_c, full_c, push_ok_c, drop_c;

  assign pop_c     = char_valid & char_ready;
  assign full_c    = (count == CNT_W'(DEPTH));
  assign push_ok_c = press_c & (~full_c | pop_c);
  assign drop_c    = press_c & full_c & ~pop_c;

  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    ovf_nxt   = overflow;
    if (pop_c) begin
      head_nxt = head + PTR_W'(1);
    end
    if (push_ok_c) begin
      tail_nxt = tail + PTR_W'(1);
    end
    if (push_ok_c && !pop_c) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push_ok_c && pop_c) begin
      count_nxt = count - CNT_W'(1);
    end
    if (drop_c) begin
      ovf_nxt = 1'b1;
    end else if (clear_ovf) begin
      ovf_nxt = 1'b0;
    end
    // A push landing on the new head slot only happens into an otherwise empty queue
    if (push_ok_c && (head_nxt == tail)) begin
      data_nxt = syn.ch;
    end else begin
      data_nxt = mem[head_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[tail] <= syn.ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      char_valid <= 1'b0;
      char_data  <= '0;
      overflow   <= 1'b0;
    end else begin
      head       <= head_nxt;
      tail       <= tail_nxt;
      count      <= count_nxt;
      char_valid <= (count_nxt != '0);
      char_data  <= data_nxt;
      overflow   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_char_input_queue.sv
// Self-checking bench: vector table, directed corner sequences and random traffic vs a queue model.
module tb_char_input_queue;

  localparam int TB_DEPTH = 4;
  localparam int TB_DEB   = 3;
  localparam int CNT_W    = $clog2(TB_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             strobe_in = 1'b0;
  logic [6:0]       char_in = '0;
  logic             deb_tick = 1'b0;
  logic             clear_ovf = 1'b0;
  logic             char_ready = 1'b0;
  logic             char_valid;
  logic [6:0]       char_data;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;

  char_input_queue #(.DEPTH(TB_DEPTH), .DEB_TICKS(TB_DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe_in  (strobe_in),
    .char_in    (char_in),
    .deb_tick   (deb_tick),
    .clear_ovf  (clear_ovf),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: delayed pin samples, debounced level with a tick run, and a plain queue
  bit         m_s1, m_s2;
  logic [6:0] m_c1, m_c2;
  bit         m_level, m_armed;
  int         m_n;
  logic [6:0] mq[$];
  bit         m_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_c1 = '0; m_c2 = '0;
    m_level = 0; m_armed = 0; m_n = 0;
    mq.delete();
    m_ovf = 0;
  endtask

  task automatic step(input bit stb, input logic [6:0] ch, input bit tk, input bit rdy, input bit clr);
    bit press, pop, drop;
    strobe_in = stb; char_in = ch; deb_tick = tk; char_ready = rdy; clear_ovf = clr;
    press = 0;
    // The synced level must differ from the debounced level for a run of DEB ticks after the first differing cycle
    if (m_s2 == m_level) begin
      m_armed = 0;
    end else if (!m_armed) begin
      m_armed = 1; m_n = 0;
    end else if (tk) begin
      m_n++;
      if (m_n == TB_DEB) begin
        m_level = m_s2; m_armed = 0;
        press = m_s2;
      end
    end
    pop  = (mq.size() != 0) && rdy;
    drop = 0;
    if (pop) void'(mq.pop_front());
    if (press) begin
      if (mq.size() < TB_DEPTH) mq.push_back(m_c2);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_s2 = m_s1; m_s1 = stb; m_c2 = m_c1; m_c1 = ch;
    @(posedge clk); #1;
    check("model_valid", int'(char_valid), int'(mq.size() != 0));
    check("model_count", int'(count), mq.size());
    check("model_ovf", int'(overflow), int'(m_ovf));
    if (mq.size() != 0) check("model_data", int'(char_data), int'(mq[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 7'h00, 1, 0, 0);
  endtask

  // Full press/release with a tick every cycle; push lands on high-phase cycle TB_DEB+2
  task automatic press(input logic [6:0] ch, input bit rdy_at_push, input bit clr_at_push);
    for (int k = 0; k < TB_DEB + 4; k++)
      step(1, ch, 1, (k == TB_DEB + 2) ? rdy_at_push : 1'b0, (k == TB_DEB + 2) ? clr_at_push : 1'b0);
    for (int k = 0; k < TB_DEB + 4; k++) step(0, ch, 1, 0, 0);
  endtask

  task automatic drain_expect(input logic [6:0] first, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      check({name, "_valid"}, int'(char_valid), 1);
      check({name, "_data"}, int'(char_data), int'(first) + i);
      step(0, 7'h00, 0, 1, 0);
    end
    check({name, "_empty"}, int'(char_valid), 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(char_valid), 0);
    check("rst_ovf", int'(overflow), 0);
    @(posedge clk); #1;
    model_reset();
    rst_n = 1;
  endtask

  typedef struct {
    bit         stb;
    logic [6:0] ch;
    bit         tk;
    bit         rdy;
    bit         clr;
    bit         e_valid;
    int         e_count;
    bit         e_ovf;
    logic [6:0] e_data;
  } vec_t;

  initial begin
    vec_t tbl[12];
    bit   stb;
    int   run;
    int   lat;
    logic [6:0] rch;

    model_reset();
    // Single press of 'A': push on the third counted tick, valid the cycle after, popped once
    tbl[0]  = '{1, 7'h41, 0, 0, 0, 0, 0, 0, 7'h00};
    tbl[1]  = '{1, 7'h41, 0, 0, 0, 0, 0, 0, 7'h00};
    tbl[2]  = '{1, 7'h41, 1, 0, 0, 0, 0, 0, 7'h00};
    tbl[3]  = '{1, 7'h41, 1, 0, 0, 0, 0, 0, 7'h00};
    tbl[4]  = '{1, 7'h41, 0, 0, 0, 0, 0, 0, 7'h00};
    tbl[5]  = '{1, 7'h41, 1, 0, 0, 0, 0, 0, 7'h00};
    tbl[6]  = '{1, 7'h41, 1, 0, 0, 1, 1, 0, 7'h41};
    tbl[7]  = '{1, 7'h41, 1, 0, 0, 1, 1, 0, 7'h41};
    tbl[8]  = '{1, 7'h41, 1, 1, 0, 0, 0, 0, 7'h00};
    tbl[9]  = '{1, 7'h41, 1, 1, 0, 0, 0, 0, 7'h00};
    tbl[10] = '{0, 7'h41, 1, 0, 0, 0, 0, 0, 7'h00};
    tbl[11] = '{1, 7'h41, 1, 0, 1, 0, 0, 0, 7'h00};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].stb, tbl[i].ch, tbl[i].tk, tbl[i].rdy, tbl[i].clr);
      check($sformatf("vec%0d_valid", i), int'(char_valid), int'(tbl[i].e_valid));
      check($sformatf("vec%0d_count", i), int'(count), tbl[i].e_count);
      check($sformatf("vec%0d_ovf", i), int'(overflow), int'(tbl[i].e_ovf));
      if (tbl[i].e_valid) check($sformatf("vec%0d_data", i), int'(char_data), int'(tbl[i].e_data));
    end
    idle(TB_DEB + 6);

    // Bouncing strobe never holds long enough
    for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 7'h33, 1, 0, 0);
    idle(TB_DEB + 6);
    check("bounce_count", int'(count), 0);

    // Overflow on fifth press, then in-order drain
    for (int i = 1; i <= 5; i++) press(7'(i), 0, 0);
    check("ovf_count", int'(count), TB_DEPTH);
    check("ovf_flag", int'(overflow), 1);
    drain_expect(7'h01, 4, "ovf_drain");
    step(0, 7'h00, 0, 0, 1);
    check("ovf_cleared", int'(overflow), 0);

    // Full queue with a pop in the push cycle: nothing dropped
    for (int i = 1; i <= 4; i++) press(7'(i), 0, 0);
    press(7'h05, 1, 0);
    check("fullpop_count", int'(count), TB_DEPTH);
    check("fullpop_ovf", int'(overflow), 0);
    drain_expect(7'h02, 4, "fullpop_drain");

    // clear_ovf coincident with a drop keeps overflow set
    for (int i = 1; i <= 5; i++) press(7'(i), 0, 0);
    check("clrdrop_pre", int'(overflow), 1);
    press(7'h06, 0, 1);
    check("clrdrop_hold", int'(overflow), 1);
    step(0, 7'h00, 0, 0, 1);
    check("clrdrop_clear", int'(overflow), 0);
    drain_expect(7'h01, 4, "clrdrop_drain");

    // Reset while arming with two queued entries; held strobe is debounced afresh
    press(7'h11, 0, 0);
    press(7'h12, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 7'h55, 1, 0, 0);
    check("midrst_pre_count", int'(count), 2);
    do_reset();
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      step(1, 7'h55, 1, 0, 0);
      if (char_valid) lat = k;
    end
    check("midrst_latency", lat, TB_DEB + 2);
    check("midrst_count", int'(count), 1);
    check("midrst_data", int'(char_data), 7'h55);
    idle(TB_DEB + 6);
    step(0, 7'h00, 0, 1, 0);

    // Random traffic against the model
    stb = 0; run = 1; rch = 7'h20;
    for (int i = 0; i < 3000; i++) begin
      run--;
      if (run <= 0) begin
        stb = ~stb;
        run = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14));
        if (stb) rch = 7'($urandom_range(0, 127));
      end
      step(stb, rch, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/char_input_queue.md
CHAR_INPUT_QUEUE -- requirements
Module: char_input_queue

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-002 Parameter DEB_TICKS, default 3: consecutive deb_tick pulses a strobe level must hold to be accepted; 1..15.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 strobe_in  input  1  raw, asynchronous, bouncy character-available pin.
REQ-006 char_in  input  7  raw asynchronous character code; held stable by the user while strobe_in is high.
REQ-007 deb_tick  input  1  one-clk-wide debounce timebase pulse from the clock divider.
REQ-008 clear_ovf  input  1  synchronous clear of overflow.
REQ-009 char_valid  output  1  head-of-queue character available to the animator.
REQ-010 char_data  output  7  head-of-queue character; don't-care while char_valid=0.
REQ-011 char_ready  input  1  animator accepts char_data this cycle.
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 overflow  output  1  sticky: a press was dropped because the queue was full.

Function
REQ-014 strobe_in and each char_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounce FSM states: LOW, ARM_HIGH, HIGH, ARM_LOW; tick counter counts deb_tick pulses only.
REQ-016 LOW -> ARM_HIGH when sync strobe=1, counter cleared; ARM_HIGH -> LOW immediately when sync strobe=0.
REQ-017 ARM_HIGH -> HIGH on the deb_tick that makes the counter reach DEB_TICKS; that same cycle SHALL produce a one-cycle press event.
REQ-018 HIGH -> ARM_LOW when sync strobe=0; ARM_LOW -> HIGH when sync strobe=1; ARM_LOW -> LOW after DEB_TICKS ticks of stable low; no event on release.
REQ-019 A press event SHALL push the synchronized char_in value present in that cycle.
REQ-020 Push when not full SHALL write the tail and increment count; push when full without a same-cycle pop SHALL be dropped and set overflow.
REQ-021 Pop occurs when char_valid & char_ready; it SHALL advance the head and decrement count.
REQ-022 Simultaneous push and pop SHALL both take effect, count unchanged, including when full (no overflow) and non-empty.
REQ-023 Push into an empty queue SHALL assert char_valid the following cycle; no same-cycle fall-through.
REQ-024 char_ready while char_valid=0 SHALL be ignored.
REQ-025 char_valid = (count != 0); char_data SHALL remain stable while char_valid=1 and char_ready=0.
REQ-026 Head/tail pointers SHALL wrap modulo DEPTH; count saturates neither above DEPTH nor below 0.
REQ-027 overflow SHALL clear on clear_ovf; a drop in the same cycle as clear_ovf SHALL leave overflow=1.
REQ-028 Press-to-valid latency: 2 sync clocks + DEB_TICKS deb_tick pulses + 1 clock.

Reset
REQ-029 On rst_n=0, asynchronously: FSM=LOW, tick counter=0, pointers=0, count=0, char_valid=0, overflow=0, synchronizer flops=0.
REQ-030 FIFO storage SHALL NOT require reset; char_data reads 0 only by virtue of being don't-care.
REQ-031 Reset mid-debounce or with a non-empty queue SHALL discard all state; a strobe held high across deassertion SHALL be debounced afresh as a new press.

Structure
REQ-032 Package char_queue_pkg SHALL hold the debounce state enum, DEPTH/DEB_TICKS defaults and the 7-bit character width constant.
REQ-033 One sub-module, sync_2ff (parameterized width, async active-low reset), SHALL implement REQ-014; FIFO and FSM stay in this module.

Verification
REQ-034 char_in=7'h41, strobe high for 5 ticks, char_ready=1 -> exactly one char_valid cycle with char_data=7'h41 at REQ-028 latency.
REQ-035 Strobe toggling every 2 clocks for 20 clocks, no steady high for 3 ticks -> no push, count=0.
REQ-036 5 presses (7'h01..7'h05), char_ready=0 -> count=4, overflow=1, then draining yields 01,02,03,04 in order.
REQ-037 Full queue, press accepted in same cycle as pop -> count stays 4, overflow stays 0, new char appears last.
REQ-038 rst_n pulsed low while in ARM_HIGH with count=2 -> count=0, char_valid=0 immediately; held strobe yields one new press after DEB_TICKS ticks.
REQ-039 overflow=1, clear_ovf coincident with a dropped press -> overflow remains 1; clear_ovf alone next cycle -> overflow=0.
